// File: rtl/pwm_cfg_sequencer.sv
// APB master that programs a pwm_apb_ip instance (CTRL off, ARR, CCR1, CCR2, CTRL on)
// and optionally reads every register back to confirm the values landed.
module pwm_cfg_sequencer #(
    parameter logic [15:0] ARR_INIT   = 16'd9999,
    parameter logic [15:0] CCR1_INIT  = 16'd2500,
    parameter logic [15:0] CCR2_INIT  = 16'd7500,
    parameter logic [2:0]  CTRL_INIT  = 3'b111,
    parameter bit          VERIFY     = 1'b1,
    parameter bit          AUTO_START = 1'b1,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  err_step,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [11:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata,
    output logic [2:0]  state_dbg
);

    // APB handshake: a transfer is one SETUP cycle (psel=1, penable=0) followed by
    // ACCESS cycles (psel=1, penable=1); it completes on the first ACCESS edge with
    // pready=1. Address, data and direction hold from SETUP until completion.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [11:0] ADDR_ARR  = 12'h000;
    localparam logic [11:0] ADDR_CCR1 = 12'h004;
    localparam logic [11:0] ADDR_CCR2 = 12'h008;
    localparam logic [11:0] ADDR_CTRL = 12'h00C;
    localparam logic [3:0]  LAST_STEP = VERIFY ? 4'd8 : 4'd4;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        err_q, err_d;
    logic [3:0]  err_step_q, err_step_d;
    logic        auto_q;

    logic [11:0] step_addr;
    logic [31:0] step_wdata;
    logic        step_write;
    logic [31:0] exp_val;
    logic [31:0] cmp_mask;
    logic        xfer_active;
    logic        rd_mismatch;
    logic        timed_out;

    // Step table: CTRL is cleared first so no channel runs on stale period/compare values.
    always_comb begin
        step_addr  = 12'h000;
        step_wdata = 32'h0;
        step_write = 1'b0;
        exp_val    = 32'h0;
        cmp_mask   = 32'h0;
        case (step_q)
            4'd0: begin step_addr = ADDR_CTRL; step_write = 1'b1; step_wdata = 32'h0; end
            4'd1: begin step_addr = ADDR_ARR;  step_write = 1'b1; step_wdata = {16'h0, ARR_INIT};  end
            4'd2: begin step_addr = ADDR_CCR1; step_write = 1'b1; step_wdata = {16'h0, CCR1_INIT}; end
            4'd3: begin step_addr = ADDR_CCR2; step_write = 1'b1; step_wdata = {16'h0, CCR2_INIT}; end
            4'd4: begin step_addr = ADDR_CTRL; step_write = 1'b1; step_wdata = {29'h0, CTRL_INIT}; end
            4'd5: begin step_addr = ADDR_ARR;  exp_val = {16'h0, ARR_INIT};  cmp_mask = 32'h0000_FFFF; end
            4'd6: begin step_addr = ADDR_CCR1; exp_val = {16'h0, CCR1_INIT}; cmp_mask = 32'h0000_FFFF; end
            4'd7: begin step_addr = ADDR_CCR2; exp_val = {16'h0, CCR2_INIT}; cmp_mask = 32'h0000_FFFF; end
            4'd8: begin step_addr = ADDR_CTRL; exp_val = {29'h0, CTRL_INIT}; cmp_mask = 32'h0000_0007; end
            default: begin step_addr = 12'h000; end
        endcase
    end

    assign rd_mismatch = !step_write && (((prdata ^ exp_val) & cmp_mask) != 32'h0);
    assign timed_out   = ({1'b0, tcnt_q} + 9'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tcnt_d     = tcnt_q;
        err_d      = err_q;
        err_step_d = err_step_q;
        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    state_d    = S_SETUP;
                    step_d     = 4'd0;
                    tcnt_d     = 8'd0;
                    err_d      = 1'b0;
                    err_step_d = 4'd0;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                tcnt_d  = 8'd0;
            end
            S_ACCESS: begin
                // A late pready in the final timeout cycle still wins.
                if (pready) begin
                    if (rd_mismatch) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_step_d = step_q;
                    end else if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        step_d  = step_q + 4'd1;
                    end
                end else if (timed_out) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_step_d = step_q;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_q     <= 4'd0;
            tcnt_q     <= 8'd0;
            err_q      <= 1'b0;
            err_step_q <= 4'd0;
            auto_q     <= AUTO_START;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tcnt_q     <= tcnt_d;
            err_q      <= err_d;
            err_step_q <= err_step_d;
            auto_q     <= 1'b0;
        end
    end

    assign xfer_active = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign psel        = xfer_active;
    assign penable     = (state_q == S_ACCESS);
    assign pwrite      = xfer_active && step_write;
    assign paddr       = xfer_active ? step_addr : 12'h000;
    assign pwdata      = (xfer_active && step_write) ? step_wdata : 32'h0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign err_step    = err_step_q;
    assign state_dbg   = state_q;

endmodule
